// File: rtl/eq_gain_ctrl_pkg.sv
// Shared definitions for the EQ gain controller: FSM states, frame header,
// band indices, select codes and the largest legal shift value.
package eq_gain_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BAND  = 3'd1,
        ST_SEL   = 3'd2,
        ST_VHI   = 3'd3,
        ST_VLO   = 3'd4,
        ST_CSUM  = 3'd5,
        ST_APPLY = 3'd6
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;

    localparam int NUM_BANDS = 5;
    localparam logic [2:0] BAND_100_1K = 3'd0;
    localparam logic [2:0] BAND_1K_3K  = 3'd1;
    localparam logic [2:0] BAND_3K_5K  = 3'd2;
    localparam logic [2:0] BAND_5K_8K  = 3'd3;
    localparam logic [2:0] BAND_6K_15K = 3'd4;

    localparam logic [1:0] SEL_SHIFT1 = 2'd0;
    localparam logic [1:0] SEL_SHIFT2 = 2'd1;
    localparam logic [1:0] SEL_BOTH   = 2'd2;

    localparam int MAX_SHIFT = 31;

endpackage

// File: rtl/eq_cmd_parser.sv
// Byte-stream command parser: frames, validates and times out gain commands.
//  state | meaning
//  IDLE  | waiting for header byte, other bytes dropped
//  BAND  | waiting for band index
//  SEL   | waiting for stage select
//  VHI   | waiting for value high byte
//  VLO   | waiting for value low byte
//  CSUM  | waiting for checksum, frame validated on acceptance
//  APPLY | one cycle, cmd_ok high, rx_ready low
module eq_cmd_parser
    import eq_gain_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       cmd_ok,
    output logic       cmd_err,
    output logic [2:0] cmd_band,
    output logic [1:0] cmd_sel,
    output logic [4:0] cmd_value
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    logic [7:0]    band_b, sel_b, vhi_b, vlo_b;
    logic [TW-1:0] tmo_cnt;
    logic          accept;
    logic          frame_ok;

    assign rx_ready = (state != ST_APPLY);
    assign accept   = rx_valid && rx_ready;

    assign frame_ok = (band_b <= 8'(BAND_6K_15K)) &&
                      (sel_b <= 8'(SEL_BOTH)) &&
                      ({vhi_b, vlo_b} <= 16'(MAX_SHIFT)) &&
                      ((band_b ^ sel_b ^ vhi_b ^ vlo_b) == rx_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            band_b    <= '0;
            sel_b     <= '0;
            vhi_b     <= '0;
            vlo_b     <= '0;
            tmo_cnt   <= '0;
            cmd_ok    <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_band  <= '0;
            cmd_sel   <= '0;
            cmd_value <= '0;
        end else begin
            cmd_ok  <= 1'b0;
            cmd_err <= 1'b0;
            if (state == ST_APPLY) begin
                state   <= ST_IDLE;
                tmo_cnt <= '0;
            end else if (accept) begin
                tmo_cnt <= '0;
                case (state)
                    ST_IDLE: if (rx_data == HDR_BYTE) state <= ST_BAND;
                    ST_BAND: begin band_b <= rx_data; state <= ST_SEL;  end
                    ST_SEL:  begin sel_b  <= rx_data; state <= ST_VHI;  end
                    ST_VHI:  begin vhi_b  <= rx_data; state <= ST_VLO;  end
                    ST_VLO:  begin vlo_b  <= rx_data; state <= ST_CSUM; end
                    ST_CSUM: begin
                        if (frame_ok) begin
                            state     <= ST_APPLY;
                            cmd_ok    <= 1'b1;
                            cmd_band  <= band_b[2:0];
                            cmd_sel   <= sel_b[1:0];
                            cmd_value <= vlo_b[4:0];
                        end else begin
                            state   <= ST_IDLE;
                            cmd_err <= 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                // Inter-byte stall inside a frame: give up once the budget is spent.
                if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
                    state   <= ST_IDLE;
                    cmd_err <= 1'b1;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eq_gain_ctrl.sv
// EQ gain controller top: parser feeds shadow registers that commit to the
// filter bank outputs only on an audio sample strobe.
module eq_gain_ctrl
    import eq_gain_ctrl_pkg::*;
#(
    parameter int DEF_SHIFT1  = 6,
    parameter int DEF_SHIFT2  = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic        clk_enable,
    output logic [15:0] filter_gain_100_1k_1,
    output logic [15:0] filter_gain_100_1k_2,
    output logic [15:0] filter_gain_1k_3k_1,
    output logic [15:0] filter_gain_1k_3k_2,
    output logic [15:0] filter_gain_3k_5k_1,
    output logic [15:0] filter_gain_3k_5k_2,
    output logic [15:0] filter_gain_5k_8k_1,
    output logic [15:0] filter_gain_5k_8k_2,
    output logic [15:0] filter_gain_6k_15k_1,
    output logic [15:0] filter_gain_6k_15k_2,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [7:0]  err_count
);

    logic [2:0]  cmd_band;
    logic [1:0]  cmd_sel;
    logic [4:0]  cmd_value;
    logic        pending;
    logic [15:0] shadow1 [NUM_BANDS];
    logic [15:0] shadow2 [NUM_BANDS];
    logic [15:0] gain1   [NUM_BANDS];
    logic [15:0] gain2   [NUM_BANDS];

    eq_cmd_parser #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_parser (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .cmd_ok    (cmd_ok),
        .cmd_err   (cmd_err),
        .cmd_band  (cmd_band),
        .cmd_sel   (cmd_sel),
        .cmd_value (cmd_value)
    );

    // Commit reads shadows before the APPLY write lands, so a strobe during
    // APPLY publishes the previous shadow and leaves the new value pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= 1'b0;
            err_count <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow1[b] <= 16'(DEF_SHIFT1);
                shadow2[b] <= 16'(DEF_SHIFT2);
                gain1[b]   <= 16'(DEF_SHIFT1);
                gain2[b]   <= 16'(DEF_SHIFT2);
            end
        end else begin
            if (cmd_err && err_count != 8'hFF) err_count <= err_count + 8'd1;

            if (clk_enable && pending) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    gain1[b] <= shadow1[b];
                    gain2[b] <= shadow2[b];
                end
            end

            if (cmd_ok) begin
                pending <= 1'b1;
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (cmd_band == 3'(b)) begin
                        if (cmd_sel == SEL_SHIFT1 || cmd_sel == SEL_BOTH)
                            shadow1[b] <= {11'd0, cmd_value};
                        if (cmd_sel == SEL_SHIFT2 || cmd_sel == SEL_BOTH)
                            shadow2[b] <= {11'd0, cmd_value};
                    end
                end
            end else if (clk_enable) begin
                pending <= 1'b0;
            end
        end
    end

    assign filter_gain_100_1k_1 = gain1[BAND_100_1K];
    assign filter_gain_100_1k_2 = gain2[BAND_100_1K];
    assign filter_gain_1k_3k_1  = gain1[BAND_1K_3K];
    assign filter_gain_1k_3k_2  = gain2[BAND_1K_3K];
    assign filter_gain_3k_5k_1  = gain1[BAND_3K_5K];
    assign filter_gain_3k_5k_2  = gain2[BAND_3K_5K];
    assign filter_gain_5k_8k_1  = gain1[BAND_5K_8K];
    assign filter_gain_5k_8k_2  = gain2[BAND_5K_8K];
    assign filter_gain_6k_15k_1 = gain1[BAND_6K_15K];
    assign filter_gain_6k_15k_2 = gain2[BAND_6K_15K];

endmodule

// File: tb/tb_eq_gain_ctrl.sv
// Directed self-checking bench for eq_gain_ctrl with hand-computed expectations.
module tb_eq_gain_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        clk_enable = 1'b0;
    logic [15:0] g1 [5];
    logic [15:0] g2 [5];
    logic        cmd_ok, cmd_err;
    logic [7:0]  err_count;

    logic [15:0] exp1 [5];
    logic [15:0] exp2 [5];
    int          n_cmp = 0;
    int          n_err = 0;
    int          waited;

    always #5 clk = ~clk;

    eq_gain_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .rx_data              (rx_data),
        .rx_valid             (rx_valid),
        .rx_ready             (rx_ready),
        .clk_enable           (clk_enable),
        .filter_gain_100_1k_1 (g1[0]),
        .filter_gain_100_1k_2 (g2[0]),
        .filter_gain_1k_3k_1  (g1[1]),
        .filter_gain_1k_3k_2  (g2[1]),
        .filter_gain_3k_5k_1  (g1[2]),
        .filter_gain_3k_5k_2  (g2[2]),
        .filter_gain_5k_8k_1  (g1[3]),
        .filter_gain_5k_8k_2  (g2[3]),
        .filter_gain_6k_15k_1 (g1[4]),
        .filter_gain_6k_15k_2 (g2[4]),
        .cmd_ok               (cmd_ok),
        .cmd_err              (cmd_err),
        .err_count            (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int b = 0; b < 5; b++) begin
            check($sformatf("%s band%0d shift1", tag, b), {16'd0, g1[b]}, {16'd0, exp1[b]});
            check($sformatf("%s band%0d shift2", tag, b), {16'd0, g2[b]}, {16'd0, exp2[b]});
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int tries;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        tries = 0;
        while (!rx_ready && tries < 4) begin
            @(negedge clk);
            tries++;
        end
        if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                              input logic [7:0] b4, input logic [7:0] b5);
        send_byte(8'hA5);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(b4);
        send_byte(b5);
    endtask

    task automatic strobe();
        @(negedge clk);
        clk_enable = 1'b1;
        @(negedge clk);
        clk_enable = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int b = 0; b < 5; b++) begin
            exp1[b] = 16'd6;
            exp2[b] = 16'd5;
        end

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset rx_ready", 32'(rx_ready), 32'd1);
        check("reset cmd_ok", 32'(cmd_ok), 32'd0);
        check("reset cmd_err", 32'(cmd_err), 32'd0);
        check("reset err_count", 32'(err_count), 32'd0);
        check_outputs("reset");

        // Band 2 shift1 = 10: cmd_ok one cycle after csum, outputs wait for strobe
        send_frame(8'h02, 8'h00, 8'h00, 8'h0A, 8'h08);
        @(negedge clk);
        check("f1 cmd_ok", 32'(cmd_ok), 32'd1);
        check("f1 rx_ready in apply", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("f1 cmd_ok falls", 32'(cmd_ok), 32'd0);
        check("f1 rx_ready back", 32'(rx_ready), 32'd1);
        check_outputs("f1 before strobe");
        strobe();
        exp1[2] = 16'd10;
        check_outputs("f1 after strobe");

        // Junk bytes in IDLE are silently dropped
        send_byte(8'h33);
        send_byte(8'h00);
        @(negedge clk);
        check("junk cmd_err", 32'(cmd_err), 32'd0);
        check("junk err_count", 32'(err_count), 32'd0);

        // Band 4 both stages = 3
        send_frame(8'h04, 8'h02, 8'h00, 8'h03, 8'h05);
        @(negedge clk);
        check("f2 cmd_ok", 32'(cmd_ok), 32'd1);
        strobe();
        exp1[4] = 16'd3;
        exp2[4] = 16'd3;
        check_outputs("f2");

        // Value 32 rejected
        send_frame(8'h01, 8'h00, 8'h00, 8'h20, 8'h21);
        @(negedge clk);
        check("v32 cmd_err", 32'(cmd_err), 32'd1);
        check("v32 cmd_ok", 32'(cmd_ok), 32'd0);
        @(negedge clk);
        check("v32 err_count", 32'(err_count), 32'd1);
        strobe();
        check_outputs("v32");

        // Band 5 and sel 3 rejected, value 256 rejected
        send_frame(8'h05, 8'h00, 8'h00, 8'h01, 8'h04);
        @(negedge clk);
        check("band5 cmd_err", 32'(cmd_err), 32'd1);
        send_frame(8'h00, 8'h03, 8'h00, 8'h01, 8'h02);
        @(negedge clk);
        check("sel3 cmd_err", 32'(cmd_err), 32'd1);
        send_frame(8'h00, 8'h00, 8'h01, 8'h00, 8'h01);
        @(negedge clk);
        check("v256 cmd_err", 32'(cmd_err), 32'd1);
        @(negedge clk);
        check("after rejects err_count", 32'(err_count), 32'd4);

        // Value 31 is the largest legal shift
        send_frame(8'h00, 8'h01, 8'h00, 8'h1F, 8'h1E);
        @(negedge clk);
        check("v31 cmd_ok", 32'(cmd_ok), 32'd1);
        strobe();
        exp2[0] = 16'd31;
        check_outputs("v31");

        // Inter-byte timeout after A5 00
        send_byte(8'hA5);
        send_byte(8'h00);
        waited = 0;
        for (int i = 1; i <= 1200; i++) begin
            @(negedge clk);
            if (cmd_err) begin
                waited = i;
                break;
            end
        end
        check("timeout fired", 32'(cmd_err), 32'd1);
        check("timeout latency window", 32'(waited >= 1000 && waited <= 1002), 32'd1);
        check("timeout rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        check("timeout err_count", 32'(err_count), 32'd5);
        send_frame(8'h01, 8'h01, 8'h00, 8'h07, 8'h07);
        @(negedge clk);
        check("post-timeout cmd_ok", 32'(cmd_ok), 32'd1);
        strobe();
        exp2[1] = 16'd7;
        check_outputs("post-timeout");

        // Strobe during APPLY: pending 9 publishes, 12 waits for next strobe
        send_frame(8'h03, 8'h00, 8'h00, 8'h09, 8'h0A);
        @(negedge clk);
        check("pend9 cmd_ok", 32'(cmd_ok), 32'd1);
        @(negedge clk);
        send_frame(8'h03, 8'h00, 8'h00, 8'h0C, 8'h0F);
        clk_enable = 1'b1;
        @(negedge clk);
        check("apply+strobe cmd_ok", 32'(cmd_ok), 32'd1);
        @(posedge clk);
        #1 clk_enable = 1'b0;
        @(negedge clk);
        exp1[3] = 16'd9;
        check_outputs("apply+strobe");
        strobe();
        exp1[3] = 16'd12;
        check_outputs("next strobe");

        // err_count saturation
        for (int k = 0; k < 300; k++) send_frame(8'h00, 8'h00, 8'h00, 8'h01, 8'hFF);
        repeat (2) @(negedge clk);
        check("sat err_count", 32'(err_count), 32'd255);
        send_frame(8'h00, 8'h00, 8'h00, 8'h01, 8'hFF);
        repeat (2) @(negedge clk);
        check("sat no wrap", 32'(err_count), 32'd255);

        // Reset mid-frame abandons it without cmd_err
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset cmd_err", 32'(cmd_err), 32'd0);
        check("midreset rx_ready", 32'(rx_ready), 32'd1);
        check("midreset err_count", 32'(err_count), 32'd0);
        for (int b = 0; b < 5; b++) begin
            exp1[b] = 16'd6;
            exp2[b] = 16'd5;
        end
        check_outputs("midreset");
        send_byte(8'h00);
        send_byte(8'h0A);
        send_byte(8'h08);
        @(negedge clk);
        check("tail cmd_ok", 32'(cmd_ok), 32'd0);
        check("tail cmd_err", 32'(cmd_err), 32'd0);
        strobe();
        check_outputs("tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
